// File: rtl/sparceMemPkg.sv
// Shared types for the sparse memory command path: opcodes, command struct, field widths.
package sparceMemPkg;

  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_op_e;

  typedef struct packed {
    mem_op_e                opcode;
    logic [ADDR_WIDTH-1:0]  address;
    logic [DATA_WIDTH-1:0]  data;
  } mem_cmd_t;

endpackage

// File: rtl/sparce_mem_cmd_queue_if.sv
// One valid/ready command channel; master drives the command, slave returns ready.
interface sparce_mem_cmd_queue_if;
  import sparceMemPkg::*;

  logic                  valid;
  logic                  ready;
  mem_op_e               opcode;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;

  modport master (
    output valid,
    output opcode,
    output addr,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  opcode,
    input  addr,
    input  data,
    output ready
  );

endinterface

// File: rtl/sparce_mem_cmdq_storage.sv
// Command entry array: one synchronous write port, one asynchronous read port, not reset.
module sparce_mem_cmdq_storage
  import sparceMemPkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  mem_cmd_t                 wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output mem_cmd_t                 rdata
);

  mem_cmd_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sparce_mem_cmd_queue.sv
// In-order command FIFO in front of the sparse memory core; NOPs are dropped at entry.
// Optional zero-latency empty-queue bypass is enabled by SPARCE_MEM_CMDQ_BYPASS_EN.
module sparce_mem_cmd_queue
  import sparceMemPkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  sparce_mem_cmd_queue_if.slave     in_if,
  sparce_mem_cmd_queue_if.master    out_if,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  mem_cmd_t      in_cmd, head, out_cmd;
  logic          is_cmd, push, pop;

  // One extra pointer bit distinguishes full from empty when the low bits match.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[PW-2:0] == rd_q[PW-2:0]);
  assign count = wr_q - rd_q;

  always_comb begin
    in_cmd.opcode  = in_if.opcode;
    in_cmd.address = in_if.addr;
    in_cmd.data    = in_if.data;
  end

  assign is_cmd = (in_if.opcode != MEM_NOP);

  always_comb begin
    in_if.ready  = !full && !rst;
    out_if.valid = !empty;
    out_cmd      = empty ? mem_cmd_t'('0) : head;
    push         = in_if.valid && in_if.ready && is_cmd;
    pop          = !empty && out_if.ready;
`ifdef SPARCE_MEM_CMDQ_BYPASS_EN
    if (empty && in_if.valid && is_cmd && !flush && !rst) begin
      out_if.valid = 1'b1;
      out_cmd      = in_cmd;
      // Consumed straight through: never written, pointers stay put.
      if (out_if.ready) begin
        push = 1'b0;
      end
    end
`endif
    wr_d = wr_q;
    rd_d = rd_q;
    if (push) begin
      wr_d = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_comb begin
    out_if.opcode = out_cmd.opcode;
    out_if.addr   = out_cmd.address;
    out_if.data   = out_cmd.data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  sparce_mem_cmdq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_q[PW-2:0]),
    .wdata (in_cmd),
    .raddr (rd_q[PW-2:0]),
    .rdata (head)
  );

endmodule

// File: tb/tb_sparce_mem_cmd_queue.sv
// Directed bench for sparce_mem_cmd_queue (DEPTH = 8), one task per scenario.
module tb_sparce_mem_cmd_queue;
  import sparceMemPkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [3:0] count;
  logic       full;
  logic       empty;

  int n_checks = 0;
  int n_fail   = 0;

  sparce_mem_cmd_queue_if in_if ();
  sparce_mem_cmd_queue_if out_if ();

  sparce_mem_cmd_queue #(
    .DEPTH (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .in_if  (in_if),
    .out_if (out_if),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input mem_op_e op, input logic [15:0] a,
                       input logic [31:0] d);
    in_if.valid  = v;
    in_if.opcode = op;
    in_if.addr   = a;
    in_if.data   = d;
  endtask

  task automatic test_reset();
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
    n_checks++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_if.valid); end
    n_checks++; if (in_if.ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0", in_if.ready); end
    n_checks++; if (out_if.addr !== 16'h0) begin n_fail++; $display("FAIL reset_out_addr got %h exp 0", out_if.addr); end
    @(negedge clk);
    rst = 1'b0;
    step();
    n_checks++; if (in_if.ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %b exp 1", in_if.ready); end
  endtask

  task automatic test_single();
    out_if.ready = 1'b0;
    drive(1'b1, MEM_WRITE, 16'h10, 32'hAB);
    step();
    drive(1'b0, MEM_NOP, 16'h0, 32'h0);
    n_checks++; if (out_if.valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", out_if.valid); end
    n_checks++; if (out_if.addr !== 16'h10) begin n_fail++; $display("FAIL single_addr got %h exp 10", out_if.addr); end
    n_checks++; if (out_if.data !== 32'hAB) begin n_fail++; $display("FAIL single_data got %h exp ab", out_if.data); end
    n_checks++; if (out_if.opcode !== MEM_WRITE) begin n_fail++; $display("FAIL single_op got %0d exp 2", out_if.opcode); end
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL single_count got %0d exp 1", count); end
    out_if.ready = 1'b1;
    step();
    out_if.ready = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_drain_empty got %b exp 1", empty); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, MEM_WRITE, 16'(i), 32'h100 + 32'(i));
      step();
    end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b exp 1", full); end
    n_checks++; if (in_if.ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got %b exp 0", in_if.ready); end
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill_count got %0d exp 8", count); end
    drive(1'b1, MEM_WRITE, 16'h99, 32'h99);
    step();
    drive(1'b0, MEM_NOP, 16'h0, 32'h0);
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_push_count got %0d exp 8", count); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (out_if.valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d] got %b exp 1", i, out_if.valid); end
      n_checks++; if (out_if.addr !== 16'(i)) begin n_fail++; $display("FAIL drain_addr[%0d] got %h exp %h", i, out_if.addr, 16'(i)); end
      n_checks++; if (out_if.data !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL drain_data[%0d] got %h exp %h", i, out_if.data, 32'h100 + 32'(i)); end
      out_if.ready = 1'b1;
      step();
    end
    out_if.ready = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b exp 1", empty); end
    n_checks++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL drain_out_valid got %b exp 0", out_if.valid); end
  endtask

  task automatic test_back_to_back();
    out_if.ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, MEM_READ, 16'h40 + 16'(i), 32'(i));
      step();
      n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL b2b_count[%0d] got %0d exp 1", i, count); end
      n_checks++; if (out_if.addr !== 16'h40 + 16'(i)) begin n_fail++; $display("FAIL b2b_addr[%0d] got %h exp %h", i, out_if.addr, 16'h40 + 16'(i)); end
    end
    drive(1'b0, MEM_NOP, 16'h0, 32'h0);
    step();
    out_if.ready = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty got %b exp 1", empty); end
  endtask

  task automatic test_nop();
    drive(1'b1, MEM_NOP, 16'h33, 32'h33);
    #1;
    n_checks++; if (in_if.ready !== 1'b1) begin n_fail++; $display("FAIL nop_in_ready got %b exp 1", in_if.ready); end
    step();
    drive(1'b0, MEM_NOP, 16'h0, 32'h0);
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL nop_count got %0d exp 0", count); end
    n_checks++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL nop_out_valid got %b exp 0", out_if.valid); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, MEM_WRITE, 16'h20 + 16'(i), 32'(i));
      step();
    end
    n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL flush_pre_count got %0d exp 5", count); end
    flush = 1'b1;
    out_if.ready = 1'b1;
    drive(1'b1, MEM_READ, 16'h3, 32'h0);
    step();
    flush = 1'b0;
    out_if.ready = 1'b0;
    drive(1'b0, MEM_NOP, 16'h0, 32'h0);
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL flush_count got %0d exp 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty got %b exp 1", empty); end
    n_checks++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b exp 0", out_if.valid); end
    drive(1'b1, MEM_WRITE, 16'h77, 32'h7);
    step();
    drive(1'b0, MEM_NOP, 16'h0, 32'h0);
    n_checks++; if (out_if.addr !== 16'h77) begin n_fail++; $display("FAIL flush_after_addr got %h exp 77", out_if.addr); end
    out_if.ready = 1'b1;
    step();
    out_if.ready = 1'b0;
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, MEM_WRITE, 16'h60 + 16'(i), 32'(i));
      step();
    end
    drive(1'b0, MEM_NOP, 16'h0, 32'h0);
    n_checks++; if (count !== 4'd4) begin n_fail++; $display("FAIL rst_pre_count got %0d exp 4", count); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL rst_mid_count got %0d exp 0", count); end
    n_checks++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid got %b exp 0", out_if.valid); end
    n_checks++; if (in_if.ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_in_ready got %b exp 0", in_if.ready); end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, MEM_WRITE, 16'h55, 32'h5);
    step();
    drive(1'b0, MEM_NOP, 16'h0, 32'h0);
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL rst_after_count got %0d exp 1", count); end
    n_checks++; if (out_if.data !== 32'h5) begin n_fail++; $display("FAIL rst_after_data got %h exp 5", out_if.data); end
    out_if.ready = 1'b1;
    step();
    out_if.ready = 1'b0;
  endtask

  task automatic test_bypass();
    out_if.ready = 1'b1;
    drive(1'b1, MEM_READ, 16'h7, 32'h0);
    #1;
`ifdef SPARCE_MEM_CMDQ_BYPASS_EN
    n_checks++; if (out_if.valid !== 1'b1) begin n_fail++; $display("FAIL bypass_valid got %b exp 1", out_if.valid); end
    n_checks++; if (out_if.addr !== 16'h7) begin n_fail++; $display("FAIL bypass_addr got %h exp 7", out_if.addr); end
    step();
    drive(1'b0, MEM_NOP, 16'h0, 32'h0);
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL bypass_count got %0d exp 0", count); end
`else
    n_checks++; if (out_if.valid !== 1'b0) begin n_fail++; $display("FAIL no_bypass_valid got %b exp 0", out_if.valid); end
    step();
    drive(1'b0, MEM_NOP, 16'h0, 32'h0);
    n_checks++; if (out_if.addr !== 16'h7) begin n_fail++; $display("FAIL no_bypass_addr got %h exp 7", out_if.addr); end
    step();
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL no_bypass_count got %0d exp 0", count); end
`endif
    out_if.ready = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    out_if.ready = 1'b0;
    drive(1'b0, MEM_NOP, 16'h0, 32'h0);
    #1;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_nop();
    test_flush();
    test_rst_mid();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
